// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MIPS pipeline constants and slot type
// Holds the word/register-address widths, the maximum pipe_select_reg depth
// and the {valid, data} slot record used on pipeline-register boundaries.
package mips_pipe_pkg;

  localparam int WORD_W         = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int PIPE_MAX_DEPTH = 4;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
  } pipe_slot_t;

endpackage

// File: rtl/pipe_select_stage.sv
// rtl/pipe_select_stage.sv - one {valid, data} pipeline register with stall/flush
// Ports:
//   i_clock, i_reset_n : clock, asynchronous active-low reset
//   i_stall            : hold current contents
//   i_flush            : load valid=0/data=0, wins over i_stall
//   i_valid, i_data    : slot from the previous stage (or the selector)
//   o_valid, o_data    : registered slot
module pipe_select_stage
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (!i_stall) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_select_reg.sv
// rtl/pipe_select_reg.sv - pipelined N-way operand selector with valid/stall/flush
// Optional feature macro: PIPE_SELECT_SEL_CHECK_EN (out-of-range select drops
// the slot and sets sticky sel_err; otherwise the slot passes with data=0).
// Ports:
//   clock, reset_n     : clock, asynchronous active-low reset
//   in_data            : INPUTS packed operands, input k at [k*WIDTH +: WIDTH]
//   sel                : binary select, sampled with in_valid
//   in_valid           : current slot is a real instruction
//   stall, flush       : hold all stages / clear all stages (flush wins)
//   out_data,out_valid : last-stage slot
//   sel_err            : sticky out-of-range select flag
module pipe_select_reg
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int INPUTS = 4,
  parameter int DEPTH  = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [INPUTS*WIDTH-1:0]   in_data,
  input  logic [$clog2(INPUTS)-1:0] sel,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      sel_err
);

  localparam int SEL_W = $clog2(INPUTS);
  // Depth is bounded by the package maximum so the stage chain stays legal.
  localparam int N_STG = (DEPTH > PIPE_MAX_DEPTH) ? PIPE_MAX_DEPTH :
                         ((DEPTH < 1) ? 1 : DEPTH);

  logic [SEL_W:0]   w_sel_ext;
  logic             w_sel_in_range;
  logic [WIDTH-1:0] w_selected;

  logic             w_stg_valid [N_STG+1];
  logic [WIDTH-1:0] w_stg_data  [N_STG+1];

  // One extra bit lets INPUTS itself be represented, so the compare is exact
  // and folds to constant-true when INPUTS is a power of 2.
  assign w_sel_ext      = {1'b0, sel};
  assign w_sel_in_range = (w_sel_ext < (SEL_W+1)'(INPUTS));

  // Unmatched select codes fall through to the all-zero default, never X.
  always_comb begin
    w_selected = '0;
    for (int k = 0; k < INPUTS; k++) begin
      if (sel == SEL_W'(k)) begin
        w_selected = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_stg_data[0] = (in_valid && w_sel_in_range) ? w_selected : '0;

`ifdef PIPE_SELECT_SEL_CHECK_EN
  logic r_sel_err;

  assign w_stg_valid[0] = in_valid & w_sel_in_range;

  // Set only by an accepted slot; a flush in the same cycle drops the slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_err <= 1'b0;
    end else if (flush) begin
      r_sel_err <= 1'b0;
    end else if (!stall && in_valid && !w_sel_in_range) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;
`else
  assign w_stg_valid[0] = in_valid;
  assign sel_err        = 1'b0;
`endif

  for (genvar g = 0; g < N_STG; g++) begin : g_stage
    pipe_select_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_stall   (stall),
      .i_flush   (flush),
      .i_valid   (w_stg_valid[g]),
      .i_data    (w_stg_data[g]),
      .o_valid   (w_stg_valid[g+1]),
      .o_data    (w_stg_data[g+1])
    );
  end

  assign out_valid = w_stg_valid[N_STG];
  assign out_data  = w_stg_data[N_STG];

endmodule

// File: tb/tb_pipe_select_reg.sv
// tb/tb_pipe_select_reg.sv - self-checking bench for pipe_select_reg
module tb_pipe_select_reg;

  localparam logic [31:0] CA = 32'hA0A0_0001;
  localparam logic [31:0] CB = 32'hB0B0_0002;
  localparam logic [31:0] CC = 32'hC0C0_0003;
  localparam logic [31:0] CD = 32'hD0D0_0004;
  localparam logic [31:0] CE = 32'hE0E0_0005;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   sel;
  logic         in_valid, stall, flush;
  logic [31:0]  dv [5];
  logic [127:0] in4;
  logic [159:0] in5;

  logic [31:0] oa_data, ob_data, oc_data;
  logic        oa_valid, ob_valid, oc_valid;
  logic        oa_err, ob_err, oc_err;

  int total = 0;
  int bad   = 0;

  // Reference state: each pipe is a queue of {valid,data}, output at the tail.
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] qc[$];
  logic        err_c;

  typedef struct {
    logic [2:0]  sel;
    logic        v;
    logic        st;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  assign in4 = {dv[3], dv[2], dv[1], dv[0]};
  assign in5 = {dv[4], in4};

  pipe_select_reg #(.WIDTH(32), .INPUTS(4), .DEPTH(3)) dut_a (
    .clock(clk), .reset_n(rst_n), .in_data(in4), .sel(sel[1:0]),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(oa_data), .out_valid(oa_valid), .sel_err(oa_err)
  );

  pipe_select_reg #(.WIDTH(32), .INPUTS(4), .DEPTH(2)) dut_b (
    .clock(clk), .reset_n(rst_n), .in_data(in4), .sel(sel[1:0]),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(ob_data), .out_valid(ob_valid), .sel_err(ob_err)
  );

  pipe_select_reg #(.WIDTH(32), .INPUTS(5), .DEPTH(2)) dut_c (
    .clock(clk), .reset_n(rst_n), .in_data(in5), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(oc_data), .out_valid(oc_valid), .sel_err(oc_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] slot(input int s, input logic v, input int n_in);
    logic        ok;
    logic [31:0] d;
    logic        vo;
    ok = (s < n_in);
    d  = 32'h0;
    if (v && ok) d = dv[s];
`ifdef PIPE_SELECT_SEL_CHECK_EN
    vo = v && ok;
`else
    vo = v;
`endif
    return {vo, d};
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete(); qc.delete();
    repeat (3) qa.push_back(33'h0);
    repeat (2) qb.push_back(33'h0);
    repeat (2) qc.push_back(33'h0);
    err_c = 1'b0;
  endtask

  task automatic model_edge();
    logic [32:0] sa, sb, sc;
    sa = slot(int'(sel[1:0]), in_valid, 4);
    sb = sa;
    sc = slot(int'(sel), in_valid, 5);
    if (!rst_n || flush) begin
      model_reset();
    end else if (!stall) begin
      qa.push_front(sa); void'(qa.pop_back());
      qb.push_front(sb); void'(qb.pop_back());
      qc.push_front(sc); void'(qc.pop_back());
`ifdef PIPE_SELECT_SEL_CHECK_EN
      if (in_valid && sel >= 3'd5) err_c = 1'b1;
`endif
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_models();
    check("a_out", {31'h0, oa_valid, oa_data}, {31'h0, qa[$]});
    check("b_out", {31'h0, ob_valid, ob_data}, {31'h0, qb[$]});
    check("c_out", {31'h0, oc_valid, oc_data}, {31'h0, qc[$]});
    check("a_err", {63'h0, oa_err}, 64'h0);
    check("b_err", {63'h0, ob_err}, 64'h0);
    check("c_err", {63'h0, oc_err}, {63'h0, err_c});
  endtask

  initial begin
    rst_n = 1'b0; sel = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    dv[0] = CA; dv[1] = CB; dv[2] = CC; dv[3] = CD; dv[4] = CE;
    model_reset();
    tick(); tick();
    check_models();
    rst_n = 1'b1;

    // Stall scenario on the DEPTH=2 pipe: A,B, two stall cycles, C,D.
    tbl[0] = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{3'd1, 1'b1, 1'b0, 1'b0, 1'b1, CA};
    tbl[2] = '{3'd2, 1'b1, 1'b1, 1'b0, 1'b1, CA};
    tbl[3] = '{3'd3, 1'b0, 1'b1, 1'b0, 1'b1, CA};
    tbl[4] = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b1, CB};
    tbl[5] = '{3'd3, 1'b1, 1'b0, 1'b0, 1'b1, CC};
    tbl[6] = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b1, CD};
    tbl[7] = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].sel; in_valid = tbl[i].v; stall = tbl[i].st; flush = tbl[i].fl;
      tick();
      check($sformatf("tbl%0d", i), {31'h0, ob_valid, ob_data}, {31'h0, tbl[i].ev, tbl[i].ed});
      check_models();
    end

    // Latency on the DEPTH=3 pipe: single slot sel=2.
    in_valid = 1'b0; stall = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; sel = 3'd2; in_valid = 1'b1;
    tick();
    check("lat_e1", {63'h0, oa_valid}, 64'h0);
    in_valid = 1'b0;
    tick();
    check("lat_e2", {63'h0, oa_valid}, 64'h0);
    tick();
    check("lat_e3", {31'h0, oa_valid, oa_data}, {31'h0, 1'b1, CC});
    tick();
    check("lat_e4", {31'h0, oa_valid, oa_data}, 64'h0);
    check_models();

    // Flush beats stall, and the stall then holds the cleared state.
    sel = 3'd0; in_valid = 1'b1; tick();
    sel = 3'd1; tick();
    check("fl_pre", {31'h0, ob_valid, ob_data}, {31'h0, 1'b1, CA});
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1;
    tick();
    check("fl_edge", {31'h0, ob_valid, ob_data}, 64'h0);
    flush = 1'b0;
    tick(); tick();
    check("fl_hold", {31'h0, ob_valid, ob_data}, 64'h0);
    check_models();
    stall = 1'b0; in_valid = 1'b0;

    // Out-of-range select on the INPUTS=5 pipe.
    sel = 3'd6; in_valid = 1'b1; tick();
    in_valid = 1'b0; sel = 3'd0; tick();
`ifdef PIPE_SELECT_SEL_CHECK_EN
    check("oor_out", {31'h0, oc_valid, oc_data}, 64'h0);
    check("oor_err", {63'h0, oc_err}, 64'h1);
`else
    check("oor_out", {31'h0, oc_valid, oc_data}, {31'h0, 1'b1, 32'h0});
    check("oor_err", {63'h0, oc_err}, 64'h0);
`endif
    tick(); tick();
    check_models();
    flush = 1'b1; tick(); flush = 1'b0;
    check("oor_clr", {63'h0, oc_err}, 64'h0);
    check_models();

    // Asynchronous reset mid-stream.
    sel = 3'd0; in_valid = 1'b1;
    tick(); tick(); tick();
    check("rst_pre", {63'h0, oa_valid}, 64'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async", {31'h0, oa_valid, oa_data}, 64'h0);
    check_models();
    tick(); tick();
    check_models();
    #2;
    rst_n = 1'b1; sel = 3'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_models();
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 5; k++) dv[k] = $urandom;
      sel      = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      tick();
      check_models();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_select_reg.md
# pipe_select_reg

Parametrised, pipelined N-way datapath selector replacing the fixed 2:1 RegDst/ALUSrc/MemtoReg/PCSrc selectors in the MIPS pipeline. It picks one of INPUTS operands by binary select and carries the result through DEPTH register stages with valid tracking, stall hold and flush clear. It sits on pipeline-register boundaries, for example EX operand forwarding or IF next-PC selection, where the selection and the stage register are merged into one block.

## Interface
- WIDTH, 32: data width per input, 1..64.
- INPUTS, 4: number of selectable inputs, 2..8.
- DEPTH, 1: number of register stages, 1..4.
- SEL_W, derived: $clog2(INPUTS). Not user-set.
- clock  in  1  rising-edge clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  INPUTS*WIDTH  packed inputs; input k is bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  binary select, sampled with in_valid.
- in_valid  in  1  the current input is a real instruction slot.
- stall  in  1  holds all stages.
- flush  in  1  clears all stages; takes priority over stall.
- out_data  out  WIDTH  data from the last stage.
- out_valid  out  1  valid bit from the last stage.
- sel_err  out  1  sticky flag for an out-of-range select; see Configuration.

## Operation
- Each stage holds the pair {valid, data}. Stage 0 is fed by the selector. Stage k is fed by stage k-1. out_data and out_valid come from stage DEPTH-1.
- Selector rules:
  - When sel < INPUTS, the result is input[sel].
  - When sel >= INPUTS (possible only if INPUTS is not a power of 2), the data is all-zero. The result is never X.
- Advance: when stall=0 and flush=0, every stage loads its predecessor on the clock edge.
  - Stage 0 data = in_valid ? selected : 0.
  - Stage 0 valid = in_valid, subject to Configuration.
- Stall: when stall=1 and flush=0, every stage holds. in_data, sel and in_valid are ignored.
- Flush: when flush=1, every stage loads valid=0 and data=0 on the next edge, regardless of stall or in_valid. The input slot in that cycle is dropped.
- No state machine beyond the stage registers and the sel_err flop.

## Timing
- Reset (reset_n=0) acts immediately, without waiting for a clock edge. Reset values: out_data=0, out_valid=0, sel_err=0, and all stages zero. Release is synchronous to the next clock edge.
- Latency: an input accepted at edge t appears on the outputs after edge t+DEPTH-1, so out_valid is visible in cycle t+DEPTH. With DEPTH=1, the output follows the edge at which the input was accepted.
- Throughput is one slot per clock while stall=0.
- Each stall cycle adds exactly one cycle of latency. Outputs are stable for the whole stall.
- Flush during a stall: all stages are cleared, and the stall continues to hold the cleared values.
- Reset asserted mid-stream discards all slots in flight. There is no recovery of in-flight data.
- Outputs are purely registered, with no combinational path from input to output.

## Configuration
- Macro: PIPE_SELECT_SEL_CHECK_EN.
- Defined:
  - An accepted slot (in_valid=1, stall=0, flush=0) with sel >= INPUTS enters stage 0 with valid=0 and data=0.
  - On that edge, sel_err sets to 1 and stays set until reset_n or flush.
- Undefined:
  - An out-of-range select passes valid unchanged, with data=0.
  - sel_err is tied to 0, and no sel_err flop is built.
- When INPUTS is a power of 2, the check logic is constant-false in both builds.

## Structure
- The shared package mips_pipe_pkg holds:
  - WORD_W=32, REG_ADDR_W=5, PIPE_MAX_DEPTH=4.
  - The typedef pipe_slot_t {logic valid; logic [WORD_W-1:0] data}.
- Sub-module pipe_select_stage: one {valid, data} register with stall, flush and asynchronous reset. It is instantiated DEPTH times through a generate loop.
- The selector and range check stay in the top level.

## Test plan
- Reset: hold reset_n=0 mid-stream with out_valid=1. Outputs go to 0 immediately, without waiting for a clock edge, and stay 0 until the first input after release propagates.
- Latency: with DEPTH=3, INPUTS=4, in_data={D,C,B,A}, drive sel=2, in_valid=1 for one cycle. out_data=C with out_valid=1 exactly 3 edges later, then 0/0.
- Stall: with DEPTH=2, stream sels 0,1,2,3 and stall for 2 cycles after the second slot. Outputs read A,B,C,D in order with a 2-cycle gap, and no duplicate or lost slot.
- Flush priority: with DEPTH=2, two valid slots are in flight, then assert stall=1, flush=1, in_valid=1 together. After the edge, out_valid=0 and out_data=0. The held output stays 0 while stall remains high.
- Out-of-range select: with INPUTS=5, drive sel=6, in_valid=1.
  - With PIPE_SELECT_SEL_CHECK_EN: out_valid=0, sel_err=1 and stays 1, then clears after a flush.
  - Without it: out_valid=1, out_data=0, and sel_err stays 0.
